// File: rtl/fifo.sv
// Synchronous single-clock FIFO with registered read data, empty/full flags
// and an occupancy count. Pointers wrap naturally; memory is not reset.
module fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      din,
    input  logic                       wr_en,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wp_q, wp_d;
    logic [AW-1:0]         rp_q, rp_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags come from the registered count so they move in lockstep with it.
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign dout  = dout_q;

    always_comb begin
        wr_acc  = wr_en && !full;
        rd_acc  = rd_en && !empty;
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        dout_d  = dout_q;
        if (wr_acc) begin
            wp_d = wp_q + 1'b1;
        end
        if (rd_acc) begin
            rp_d   = rp_q + 1'b1;
            dout_d = mem_q[rp_q];
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

    // Storage keeps its contents across reset; only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wp_q] <= din;
        end
    end

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: a queue model predicts dout/count/flags every
// cycle from the driven stimulus alone.
module tb_fifo;

  localparam int W     = 32;
  localparam int DEPTH = 16;

  logic         clk;
  logic         rst;
  logic [W-1:0] din;
  logic         wr_en;
  logic         rd_en;
  logic [W-1:0] dout;
  logic         empty;
  logic         full;
  logic [4:0]   count;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_dout;
  int           n_checks;
  int           n_errors;

  fifo #(.DATA_WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .dout  (dout),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock of stimulus; model updates from what was driven, then DUT is compared.
  task automatic step(input logic r, input logic w, input logic rd, input logic [W-1:0] d);
    logic wacc;
    logic racc;
    @(negedge clk);
    rst   = r;
    wr_en = w;
    rd_en = rd;
    din   = w ? d : '0;
    wacc  = !r && w && (exp_q.size() != DEPTH);
    racc  = !r && rd && (exp_q.size() != 0);
    @(posedge clk);
    #1;
    if (r) begin
      exp_q.delete();
      exp_dout = '0;
    end else begin
      if (racc) exp_dout = exp_q.pop_front();
      if (wacc) exp_q.push_back(d);
    end
    check("dout", dout, exp_dout);
    check("count", W'(count), W'(exp_q.size()));
    check("empty", W'(empty), W'(exp_q.size() == 0));
    check("full", W'(full), W'(exp_q.size() == DEPTH));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_dout = '0;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;

    // reset held two cycles
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("reset_count", W'(count), 0);
    check("reset_empty", W'(empty), 1);

    // fill, then an ignored write while full
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, W'(100 + i));
    check("fill_full", W'(full), 1);
    step(0, 1, 0, 999);
    check("full_write_ignored", W'(count), 16);

    // drain, then a read while empty holds dout
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0);
    check("drain_last", dout, 115);
    step(0, 0, 1, 0);
    check("empty_read_hold", dout, 115);

    // streaming from empty: write-only first cycle, then count stays 1
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 1, W'(200 + i));
      check("stream_count", W'(count), 1);
    end
    step(0, 0, 1, 0);
    check("stream_last", dout, 215);

    // simultaneous write+read while full: only the read happens
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, W'(500 + i));
    step(0, 1, 1, 777);
    check("full_wr_rd_count", W'(count), DEPTH - 1);
    for (int i = 0; i < DEPTH - 1; i++) step(0, 0, 1, 0);

    // wrap-around
    for (int i = 0; i < 10; i++) step(0, 1, 0, W'(400 + i));
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, W'(300 + i));
    check("wrap_full", W'(full), 1);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 1, 0);
      check("wrap_order", dout, W'(300 + i));
    end

    // reset mid-operation with a simultaneous write
    for (int i = 0; i < 5; i++) step(0, 1, 0, W'(600 + i));
    step(0, 1, 1, 0);
    step(1, 1, 0, 888);
    check("midrst_count", W'(count), 0);
    check("midrst_dout", dout, 0);
    step(0, 0, 1, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom_range(0, 65535)));
    end
    while (exp_q.size() != 0) step(0, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
